fir_filter_param: RTL
=====================

// Module: fir_filter_param
// PURPOSE
//  Parametrised direct-form FIR filter. Signed samples enter through a valid/ready
//  handshake and pass down an N_TAPS-deep delay line; the output is the signed sum
//  of products of each delay-line slot and its coefficient.
//  - Coefficients are run-time writable through a register-style port.
//  - Output is registered, full precision, with back-pressure.
//  - Successor to the fixed 4-tap, 16-bit DSP stage in the sample-processing datapath.
// PARAMETERS
//  N       16                     sample and coefficient width (signed two's complement)
//  N_TAPS  4                      number of taps, >= 1
//  ACC_W   2*N+$clog2(N_TAPS)+1   accumulator/output width; guarantees no overflow
//  COEF_AW $clog2(N_TAPS)         coefficient address width (1 when N_TAPS == 1)
// PORTS
//  clk        in   1        clock; all state updates on rising edge
//  rst        in   1        synchronous, active-low reset
//  ena        in   1        global enable; 0 = freeze all state, in_ready forced 0
//  clear      in   1        synchronous flush of delay line and output stage
//  in_valid   in   1        sample is presented
//  in_ready   out  1        filter accepts a sample this cycle
//  sample     in   N        signed input sample
//  coef_we    in   1        coefficient write strobe
//  coef_addr  in   COEF_AW  tap index to write
//  coef_data  in   N        signed coefficient value
//  out_valid  out  1        out holds a valid result
//  out_ready  in   1        downstream consumes out this cycle
//  out        out  ACC_W    signed filter result
// BEHAVIOUR
//  - Reset (rst == 0 at a clock edge):
//    - Delay line and all coefficients are cleared to 0.
//    - out_valid = 0 and out = 0.
//    - Reset overrides ena, clear, coef_we and every handshake.
//  - Handshake:
//    - in_ready = ena && (!out_valid || out_ready), so the output register is never overwritten.
//    - A sample is accepted when in_valid && in_ready.
//    - An accepted sample shifts in: buf[0] <= sample, buf[k] <= buf[k-1].
//  - Output:
//    - out = SUM(k = 0..N_TAPS-1) buf'[k] * coef[k], computed from the post-shift delay line buf'.
//    - out is registered: out_valid rises on the edge after acceptance (latency 1 cycle).
//    - Throughput is one sample per cycle while out_ready == 1.
//  - out_valid clears on out_valid && out_ready unless a new sample is accepted in the same
//    cycle, in which case out and out_valid reload (out_valid stays 1).
//  - While out_valid && !out_ready: out and out_valid are held stable and in_ready = 0.
//  - Arithmetic: all products and sums are signed and sign-extended to ACC_W. No rounding,
//    no saturation.
//  - Coefficient write (coef_we): takes effect at the edge. Writes are honoured while
//    ena == 0. If coef_addr >= N_TAPS, the write is ignored.
//    - A sample accepted in the same cycle as a write uses the OLD coefficient set.
//  - clear (only while ena == 1): zeroes the delay line, out_valid and out; coefficients are kept.
//    - Any sample presented in a clear cycle is dropped (in_ready = 0 while clear == 1).
//  - ena == 0: delay line, out and out_valid hold their values; out_ready is ignored.
//  - Priority: rst > clear > ena gating > handshake.
//  - Delay-line history persists across idle gaps; there is no auto-flush.
// STRUCTURE
//  - Shared package dsp_pkg holds:
//    - localparam function acc_width(N, N_TAPS)
//    - typedef sample_t = logic signed [N-1:0]
//    - typedef coef_t = logic signed [N-1:0]
//  - Sub-module fir_tap: one delay-line register plus coefficient register and its product.
//    Instantiated N_TAPS times in a generate loop.
//  - Adder tree/sum and the output register live in the top.
// TESTING
//  1 Impulse: coef = {1,2,3,4}; feed 1,0,0,0,0 with out_ready = 1
//    -> out = 1,2,3,4,0, each one cycle after acceptance.
//  2 Extremes: N = 16, all coef = -32768, samples all -32768
//    -> 4th output = 4*2^30 = 4294967296, exact in ACC_W = 35 with no wrap.
//  3 Back-pressure: hold out_ready = 0 for 3 cycles after the first output
//    -> out stable, in_ready = 0, no sample lost; the following outputs match the golden model.
//  4 Coefficient write in the same cycle as sample acceptance
//    -> that output uses the old coefficients; the next output uses the new ones.
//    -> A write to addr = N_TAPS (non-power-of-2 config, N_TAPS = 3) is ignored.
//  5 clear mid-stream after samples 5,6,7 -> next impulse response shows no residue.
//    -> ena = 0 for 2 cycles holds all state.
//  6 rst low mid-operation with out_valid = 1
//    -> next cycle out_valid = 0, out = 0, coefficients read back 0 (impulse gives all-zero output).

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared DSP types and width helpers for the sample-processing datapath.
package dsp_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [SAMPLE_W-1:0] coef_t;

    function automatic int acc_width(input int n, input int n_taps);
        return 2 * n + $clog2(n_taps) + 1;
    endfunction

    function automatic int coef_aw(input int n_taps);
        return (n_taps > 1) ? $clog2(n_taps) : 1;
    endfunction

endpackage

// File: rtl/fir_tap.sv
// One FIR tap: a delay-line slot, its coefficient register, and the product
// of the value about to enter this slot with the current coefficient.
module fir_tap #(
    parameter int N = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_shift,
    input  logic                  i_clear,
    input  logic                  i_coef_we,
    input  logic signed [N-1:0]   i_din,
    input  logic signed [N-1:0]   i_coef_data,
    output logic signed [N-1:0]   o_tap,
    output logic signed [2*N-1:0] o_prod
);

    localparam int PW = 2 * N;

    logic signed [N-1:0] r_tap;
    logic signed [N-1:0] r_coef;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_tap  <= '0;
            r_coef <= '0;
        end else begin
            if (i_coef_we)
                r_coef <= i_coef_data;
            if (i_clear)
                r_tap <= '0;
            else if (i_shift)
                r_tap <= i_din;
        end
    end

    // i_din is this slot's post-shift value; r_coef is still the pre-write coefficient.
    assign o_tap  = r_tap;
    assign o_prod = PW'(i_din) * PW'(r_coef);

endmodule

// File: rtl/fir_filter_param.sv
// Parametrised direct-form FIR filter with valid/ready handshakes, run-time
// writable coefficients and a registered full-precision output.
module fir_filter_param
    import dsp_pkg::*;
#(
    parameter int N       = 16,
    parameter int N_TAPS  = 4,
    parameter int ACC_W   = acc_width(N, N_TAPS),
    parameter int COEF_AW = coef_aw(N_TAPS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_ena,
    input  logic                     i_clear,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic signed [N-1:0]      i_sample,
    input  logic                     i_coef_we,
    input  logic [COEF_AW-1:0]       i_coef_addr,
    input  logic signed [N-1:0]      i_coef_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic signed [ACC_W-1:0]  o_out
);

    logic                    r_out_valid;
    logic signed [ACC_W-1:0] r_out;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_flush;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [N-1:0]     w_din  [N_TAPS];
    logic signed [N-1:0]     w_tap  [N_TAPS];
    logic signed [2*N-1:0]   w_prod [N_TAPS];

    assign w_ready  = i_ena && !i_clear && (!r_out_valid || i_out_ready);
    assign w_accept = i_in_valid && w_ready;
    assign w_flush  = i_ena && i_clear;

    // Out-of-range addresses match no tap, so such writes simply vanish.
    for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
        if (k == 0) begin : g_head
            assign w_din[k] = i_sample;
        end else begin : g_chain
            assign w_din[k] = w_tap[k-1];
        end

        fir_tap #(.N(N)) u_tap (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_shift     (w_accept),
            .i_clear     (w_flush),
            .i_coef_we   (i_coef_we && (i_coef_addr == COEF_AW'(k))),
            .i_din       (w_din[k]),
            .i_coef_data (i_coef_data),
            .o_tap       (w_tap[k]),
            .o_prod      (w_prod[k])
        );
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < N_TAPS; k++)
            w_sum = w_sum + ACC_W'(w_prod[k]);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (i_ena) begin
            if (i_clear) begin
                r_out_valid <= 1'b0;
                r_out       <= '0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out       <= w_sum;
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_in_ready  = w_ready;
    assign o_out_valid = r_out_valid;
    assign o_out       = r_out;

endmodule
